// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use bubble insertion.
// Operands reach the ALU one cycle after decode; forwarding muxes are purely combinational.
module id_ex_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int OPCODE_LENGTH  = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic                      stall,
  input  logic                      flush,
  input  logic [DATA_WIDTH-1:0]     id_pc,
  input  logic [DATA_WIDTH-1:0]     id_rs1_data,
  input  logic [DATA_WIDTH-1:0]     id_rs2_data,
  input  logic [DATA_WIDTH-1:0]     id_imm,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic [OPCODE_LENGTH-1:0]  id_alu_op,
  input  logic                      id_alu_src,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  input  logic                      id_mem_write,
  input  logic                      id_branch,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic                      exmem_reg_write,
  input  logic [DATA_WIDTH-1:0]     exmem_result,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic                      memwb_reg_write,
  input  logic [DATA_WIDTH-1:0]     memwb_result,
  output logic [DATA_WIDTH-1:0]     SrcA,
  output logic [DATA_WIDTH-1:0]     SrcB,
  output logic [OPCODE_LENGTH-1:0]  Operation,
  output logic                      ex_valid,
  output logic [DATA_WIDTH-1:0]     ex_pc,
  output logic [DATA_WIDTH-1:0]     ex_store_data,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic                      ex_reg_write,
  output logic                      ex_mem_read,
  output logic                      ex_mem_write,
  output logic                      ex_branch,
  output logic                      load_use_stall,
  output logic [31:0]               bubble_count
);

  logic                      r_valid;
  logic [DATA_WIDTH-1:0]     r_pc;
  logic [DATA_WIDTH-1:0]     r_rs1_data;
  logic [DATA_WIDTH-1:0]     r_rs2_data;
  logic [DATA_WIDTH-1:0]     r_imm;
  logic [REG_ADDR_WIDTH-1:0] r_rs1;
  logic [REG_ADDR_WIDTH-1:0] r_rs2;
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  logic [OPCODE_LENGTH-1:0]  r_alu_op;
  logic                      r_alu_src;
  logic                      r_reg_write;
  logic                      r_mem_read;
  logic                      r_mem_write;
  logic                      r_branch;
  logic [31:0]               r_bubble_count;

  logic                      w_load_use;
  logic [DATA_WIDTH-1:0]     w_fwd_a;
  logic [DATA_WIDTH-1:0]     w_fwd_b;

  // A load in EX whose destination is read by decode must wait one cycle for its data.
  assign w_load_use = r_valid && r_mem_read && (r_rd != '0) && id_valid &&
                      ((r_rd == id_rs1) || (r_rd == id_rs2)) && !flush && !stall;

  // Youngest producer wins; x0 is hardwired zero and never forwarded.
  always_comb begin
    w_fwd_a = r_rs1_data;
    if (exmem_reg_write && (exmem_rd == r_rs1) && (r_rs1 != '0))
      w_fwd_a = exmem_result;
    else if (memwb_reg_write && (memwb_rd == r_rs1) && (r_rs1 != '0))
      w_fwd_a = memwb_result;
  end

  always_comb begin
    w_fwd_b = r_rs2_data;
    if (exmem_reg_write && (exmem_rd == r_rs2) && (r_rs2 != '0))
      w_fwd_b = exmem_result;
    else if (memwb_reg_write && (memwb_rd == r_rs2) && (r_rs2 != '0))
      w_fwd_b = memwb_result;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid        <= 1'b0;
      r_pc           <= '0;
      r_rs1_data     <= '0;
      r_rs2_data     <= '0;
      r_imm          <= '0;
      r_rs1          <= '0;
      r_rs2          <= '0;
      r_rd           <= '0;
      r_alu_op       <= '0;
      r_alu_src      <= 1'b0;
      r_reg_write    <= 1'b0;
      r_mem_read     <= 1'b0;
      r_mem_write    <= 1'b0;
      r_branch       <= 1'b0;
      r_bubble_count <= '0;
    end else if (flush || w_load_use) begin
      r_valid     <= 1'b0;
      r_rd        <= '0;
      r_alu_op    <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_branch    <= 1'b0;
      // Only hazard bubbles are counted; flushes are not.
      if (w_load_use && (r_bubble_count != 32'hFFFF_FFFF))
        r_bubble_count <= r_bubble_count + 32'd1;
    end else if (!stall) begin
      r_valid     <= id_valid;
      r_pc        <= id_pc;
      r_rs1_data  <= id_rs1_data;
      r_rs2_data  <= id_rs2_data;
      r_imm       <= id_imm;
      r_rs1       <= id_rs1;
      r_rs2       <= id_rs2;
      r_rd        <= id_rd;
      r_alu_op    <= id_alu_op;
      r_alu_src   <= id_alu_src;
      r_reg_write <= id_reg_write;
      r_mem_read  <= id_mem_read;
      r_mem_write <= id_mem_write;
      r_branch    <= id_branch;
    end
  end

  assign SrcA           = w_fwd_a;
  assign SrcB           = r_alu_src ? r_imm : w_fwd_b;
  assign ex_store_data  = w_fwd_b;
  assign Operation      = r_alu_op;
  assign ex_valid       = r_valid;
  assign ex_pc          = r_pc;
  assign ex_rd          = r_rd;
  assign ex_reg_write   = r_reg_write;
  assign ex_mem_read    = r_mem_read;
  assign ex_mem_write   = r_mem_write;
  assign ex_branch      = r_branch;
  assign load_use_stall = w_load_use;
  assign bubble_count   = r_bubble_count;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed scenarios plus randomized traffic against a
// transaction-level model of the EX stage contents.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n, id_valid, stall, flush;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_op;
  logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_branch;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_reg_write, memwb_reg_write;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] SrcA, SrcB, ex_pc, ex_store_data, bubble_count;
  logic [3:0]  Operation;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, load_use_stall;
  logic [4:0]  ex_rd;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  op;
    logic        alusrc, rw, mr, mw, br;
  } ex_t;

  ex_t         m;
  logic [31:0] m_bc;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .stall(stall), .flush(flush),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_branch(id_branch),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .load_use_stall(load_use_stall), .bubble_count(bubble_count)
  );

  task automatic clear_inputs();
    rst_n = 1'b1; id_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_alu_op = '0; id_alu_src = 1'b0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0; id_branch = 1'b0;
    exmem_rd = '0; exmem_reg_write = 1'b0; exmem_result = '0;
    memwb_rd = '0; memwb_reg_write = 1'b0; memwb_result = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_operand(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 0) return rf;
    if (exmem_reg_write && exmem_rd == rs) return exmem_result;
    if (memwb_reg_write && memwb_rd == rs) return memwb_result;
    return rf;
  endfunction

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0; id_valid = 1'b1; id_pc = 32'h44; id_rs1_data = 32'h1;
    id_rd = 5'd2; id_reg_write = 1'b1; id_alu_op = 4'hF; id_mem_read = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if ({ex_valid, ex_pc, ex_rd, Operation, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_branch, bubble_count, SrcA, SrcB, ex_store_data} !== '0) begin
        n_err++;
        $display("FAIL reset cyc%0d: valid=%b pc=%h rd=%0d op=%h bc=%0d srca=%h srcb=%h want all zero",
                 i, ex_valid, ex_pc, ex_rd, Operation, bubble_count, SrcA, SrcB);
      end
    end
  endtask

  task automatic test_capture();
    clear_inputs();
    id_valid = 1'b1; id_rs1_data = 32'd5; id_rs2_data = 32'd7; id_alu_op = 4'b0011;
    id_rd = 5'd3; id_rs1 = 5'd1; id_rs2 = 5'd2; id_pc = 32'h100; id_reg_write = 1'b1;
    tick();
    n_cmp++;
    if ({SrcA, SrcB, Operation, ex_rd, ex_valid, ex_pc} !==
        {32'd5, 32'd7, 4'b0011, 5'd3, 1'b1, 32'h100}) begin
      n_err++;
      $display("FAIL capture: srca=%h srcb=%h op=%h rd=%0d valid=%b pc=%h want 5 7 3 3 1 100",
               SrcA, SrcB, Operation, ex_rd, ex_valid, ex_pc);
    end
  endtask

  task automatic test_forwarding();
    clear_inputs();
    id_valid = 1'b1; id_rs1 = 5'd4; id_rs1_data = 32'h11; id_rs2 = 5'd9; id_rs2_data = 32'h22;
    tick();
    exmem_rd = 5'd4; exmem_reg_write = 1'b1; exmem_result = 32'hAA;
    memwb_rd = 5'd4; memwb_reg_write = 1'b1; memwb_result = 32'hBB;
    #1;
    n_cmp++;
    if (SrcA !== 32'hAA || SrcB !== 32'h22) begin
      n_err++;
      $display("FAIL fwd_exmem: srca=%h srcb=%h want aa 22", SrcA, SrcB);
    end
    exmem_reg_write = 1'b0;
    #1;
    n_cmp++;
    if (SrcA !== 32'hBB) begin
      n_err++;
      $display("FAIL fwd_memwb: srca=%h want bb", SrcA);
    end
    memwb_reg_write = 1'b0;
    #1;
    n_cmp++;
    if (SrcA !== 32'h11) begin
      n_err++;
      $display("FAIL fwd_none: srca=%h want 11", SrcA);
    end
    id_rs1 = 5'd0; id_rs1_data = 32'h0;
    exmem_rd = 5'd0; exmem_reg_write = 1'b1; memwb_rd = 5'd0; memwb_reg_write = 1'b1;
    tick();
    n_cmp++;
    if (SrcA !== 32'h0) begin
      n_err++;
      $display("FAIL fwd_x0: srca=%h want 0", SrcA);
    end
  endtask

  task automatic test_load_use();
    clear_inputs();
    id_valid = 1'b1; id_mem_read = 1'b1; id_reg_write = 1'b1; id_rd = 5'd6;
    id_rs1 = 5'd1; id_rs2 = 5'd2;
    tick();
    clear_inputs();
    id_valid = 1'b1; id_rs1 = 5'd1; id_rs2 = 5'd6; id_rd = 5'd7; id_alu_op = 4'd5;
    id_reg_write = 1'b1; id_rs1_data = 32'h21; id_rs2_data = 32'h22;
    #1;
    n_cmp++;
    if (load_use_stall !== 1'b1) begin
      n_err++;
      $display("FAIL lu_detect: load_use_stall=%b want 1", load_use_stall);
    end
    tick();
    n_cmp++;
    if ({ex_valid, ex_reg_write, bubble_count, load_use_stall} !== {1'b0, 1'b0, 32'd1, 1'b0}) begin
      n_err++;
      $display("FAIL lu_bubble: valid=%b rw=%b bc=%0d lu=%b want 0 0 1 0",
               ex_valid, ex_reg_write, bubble_count, load_use_stall);
    end
    tick();
    n_cmp++;
    if ({ex_valid, ex_rd, Operation} !== {1'b1, 5'd7, 4'd5}) begin
      n_err++;
      $display("FAIL lu_recapture: valid=%b rd=%0d op=%h want 1 7 5", ex_valid, ex_rd, Operation);
    end
  endtask

  task automatic test_stall();
    clear_inputs();
    id_valid = 1'b1; id_mem_read = 1'b1; id_reg_write = 1'b1; id_rd = 5'd8;
    id_alu_op = 4'd2; id_pc = 32'h200; id_rs1_data = 32'h31;
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id_valid = 1'b1; id_rs1 = 5'd8; id_rs2 = 5'($urandom); id_rd = 5'($urandom);
      id_alu_op = 4'($urandom); id_pc = $urandom; id_rs1_data = $urandom;
      #1;
      n_cmp++;
      if (load_use_stall !== 1'b0) begin
        n_err++;
        $display("FAIL stall_lu cyc%0d: load_use_stall=%b want 0", i, load_use_stall);
      end
      tick();
      n_cmp++;
      if ({ex_valid, ex_rd, Operation, ex_mem_read, ex_reg_write, ex_pc, SrcA, bubble_count} !==
          {1'b1, 5'd8, 4'd2, 1'b1, 1'b1, 32'h200, 32'h31, 32'd1}) begin
        n_err++;
        $display("FAIL stall_hold cyc%0d: valid=%b rd=%0d op=%h mr=%b pc=%h srca=%h bc=%0d",
                 i, ex_valid, ex_rd, Operation, ex_mem_read, ex_pc, SrcA, bubble_count);
      end
    end
  endtask

  task automatic test_flush();
    stall = 1'b1; flush = 1'b1; id_valid = 1'b1; id_rs1 = 5'd8;
    #1;
    n_cmp++;
    if (load_use_stall !== 1'b0) begin
      n_err++;
      $display("FAIL flush_lu: load_use_stall=%b want 0", load_use_stall);
    end
    tick();
    n_cmp++;
    if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, Operation, ex_rd} !== '0 ||
        bubble_count !== 32'd1) begin
      n_err++;
      $display("FAIL flush_bubble: valid=%b rw=%b mr=%b op=%h rd=%0d bc=%0d want zeros bc=1",
               ex_valid, ex_reg_write, ex_mem_read, Operation, ex_rd, bubble_count);
    end
    clear_inputs();
  endtask

  task automatic test_imm_sat();
    clear_inputs();
    id_valid = 1'b1; id_alu_src = 1'b1; id_imm = 32'hFFFF_FFF0; id_rs2 = 5'd5; id_rs2_data = 32'h99;
    tick();
    memwb_rd = 5'd5; memwb_reg_write = 1'b1; memwb_result = 32'h10;
    #1;
    n_cmp++;
    if (SrcB !== 32'hFFFF_FFF0 || ex_store_data !== 32'h10) begin
      n_err++;
      $display("FAIL imm_select: srcb=%h store=%h want fffffff0 10", SrcB, ex_store_data);
    end
    force dut.r_bubble_count = 32'hFFFF_FFFF;
    clear_inputs();
    id_valid = 1'b1; id_mem_read = 1'b1; id_rd = 5'd9;
    tick();
    release dut.r_bubble_count;
    clear_inputs();
    id_valid = 1'b1; id_rs1 = 5'd9;
    #1;
    n_cmp++;
    if (load_use_stall !== 1'b1) begin
      n_err++;
      $display("FAIL sat_lu: load_use_stall=%b want 1", load_use_stall);
    end
    tick();
    n_cmp++;
    if (bubble_count !== 32'hFFFF_FFFF || ex_valid !== 1'b0) begin
      n_err++;
      $display("FAIL saturate: bc=%h valid=%b want ffffffff 0", bubble_count, ex_valid);
    end
  endtask

  task automatic test_random();
    logic        exp_lu;
    logic [31:0] exp_a, exp_b, exp_st;
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m = '{valid: 1'b0, pc: '0, rs1d: '0, rs2d: '0, imm: '0, rs1: '0, rs2: '0, rd: '0,
          op: '0, alusrc: 1'b0, rw: 1'b0, mr: 1'b0, mw: 1'b0, br: 1'b0};
    m_bc = '0;
    for (int c = 0; c < 500; c++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 7) == 0);
      id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
      id_rd = 5'($urandom_range(0, 7)); id_alu_op = 4'($urandom);
      id_alu_src = 1'($urandom); id_reg_write = 1'($urandom);
      id_mem_read = ($urandom_range(0, 2) == 0); id_mem_write = 1'($urandom);
      id_branch = 1'($urandom);
      exmem_rd = 5'($urandom_range(0, 7)); exmem_reg_write = 1'($urandom); exmem_result = $urandom;
      memwb_rd = 5'($urandom_range(0, 7)); memwb_reg_write = 1'($urandom); memwb_result = $urandom;
      #1;
      exp_lu = m.valid && m.mr && m.rd != 0 && id_valid && (m.rd == id_rs1 || m.rd == id_rs2) &&
               !flush && !stall;
      exp_a  = ref_operand(m.rs1, m.rs1d);
      exp_st = ref_operand(m.rs2, m.rs2d);
      exp_b  = m.alusrc ? m.imm : exp_st;
      n_cmp++;
      if (load_use_stall !== exp_lu) begin
        n_err++;
        $display("FAIL rnd_lu c%0d: got %b want %b", c, load_use_stall, exp_lu);
      end
      n_cmp++;
      if ({ex_valid, ex_rd, Operation, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch} !==
          {m.valid, m.rd, m.op, m.rw, m.mr, m.mw, m.br}) begin
        n_err++;
        $display("FAIL rnd_ctrl c%0d: got v%b rd%0d op%h %b%b%b%b want v%b rd%0d op%h %b%b%b%b",
                 c, ex_valid, ex_rd, Operation, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch,
                 m.valid, m.rd, m.op, m.rw, m.mr, m.mw, m.br);
      end
      n_cmp++;
      if (bubble_count !== m_bc) begin
        n_err++;
        $display("FAIL rnd_bcount c%0d: got %0d want %0d", c, bubble_count, m_bc);
      end
      if (m.valid) begin
        n_cmp++;
        if ({ex_pc, SrcA, SrcB, ex_store_data} !== {m.pc, exp_a, exp_b, exp_st}) begin
          n_err++;
          $display("FAIL rnd_operands c%0d: got pc%h a%h b%h st%h want pc%h a%h b%h st%h",
                   c, ex_pc, SrcA, SrcB, ex_store_data, m.pc, exp_a, exp_b, exp_st);
        end
      end
      tick();
      if (flush || exp_lu) begin
        m.valid = 1'b0; m.rd = '0; m.op = '0;
        m.rw = 1'b0; m.mr = 1'b0; m.mw = 1'b0; m.br = 1'b0;
        if (exp_lu && m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
      end else if (!stall) begin
        m = '{valid: id_valid, pc: id_pc, rs1d: id_rs1_data, rs2d: id_rs2_data, imm: id_imm,
              rs1: id_rs1, rs2: id_rs2, rd: id_rd, op: id_alu_op, alusrc: id_alu_src,
              rw: id_reg_write, mr: id_mem_read, mw: id_mem_write, br: id_branch};
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_capture();
    test_forwarding();
    test_load_use();
    test_stall();
    test_flush();
    test_imm_sat();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule
